// File: rtl/gpio_ctrl.sv
// rtl/gpio_ctrl.sv - 16-pin memory-mapped GPIO controller on the PicoRV32 iomem bus
module gpio_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h2100_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  input  logic [15:0] gpio_in,
  output logic [15:0] gpio_out,
  output logic [15:0] gpio_oeb,
  output logic        irq
);

  localparam logic [5:0] REG_OUT     = 6'h00;
  localparam logic [5:0] REG_OE      = 6'h01;
  localparam logic [5:0] REG_IN      = 6'h02;
  localparam logic [5:0] REG_IRQ_EN  = 6'h03;
  localparam logic [5:0] REG_IRQ_POL = 6'h04;
  localparam logic [5:0] REG_STAT    = 6'h05;
  localparam logic [5:0] REG_OUT_SET = 6'h06;
  localparam logic [5:0] REG_OUT_CLR = 6'h07;

  typedef enum logic {S_IDLE, S_ACK} state_t;
  state_t state;

  logic [15:0] out_reg, oe_reg, irq_en, irq_pol, irq_stat;
  logic [15:0] sync1, sync2, prev;
  logic [15:0] wmask, wbits, hit, w1c, rd_val;
  logic [5:0]  reg_idx;
  logic        sel, do_acc, wr;

  // Upper strobes, data bits and the byte offset within a word have no register behind them
  logic unused_bits;
  assign unused_bits = ^{iomem_wstrb[3:2], iomem_addr[1:0], iomem_wdata[31:16]};

  assign sel     = iomem_valid && (iomem_addr[31:8] == BASE_ADDR[31:8]);
  assign do_acc  = (state == S_IDLE) && sel;
  assign wr      = do_acc && (iomem_wstrb != 4'b0000);
  assign reg_idx = iomem_addr[7:2];
  assign wmask   = {{8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
  assign wbits   = iomem_wdata[15:0] & wmask;

  assign hit = (irq_pol & sync2 & ~prev) | (~irq_pol & ~sync2 & prev);
  assign w1c = (wr && reg_idx == REG_STAT) ? wbits : 16'h0000;

  assign gpio_out = out_reg;
  assign gpio_oeb = ~oe_reg;
  assign irq      = |(irq_stat & irq_en);

  always_comb begin
    rd_val = 16'h0000;
    case (reg_idx)
      REG_OUT:     rd_val = out_reg;
      REG_OE:      rd_val = oe_reg;
      REG_IN:      rd_val = sync2;
      REG_IRQ_EN:  rd_val = irq_en;
      REG_IRQ_POL: rd_val = irq_pol;
      REG_STAT:    rd_val = irq_stat;
      default:     rd_val = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      iomem_ready <= 1'b0;
      iomem_rdata <= 32'h0;
      out_reg     <= 16'h0;
      oe_reg      <= 16'h0;
      irq_en      <= 16'h0;
      irq_pol     <= 16'h0;
      irq_stat    <= 16'h0;
      sync1       <= 16'h0;
      sync2       <= 16'h0;
      prev        <= 16'h0;
    end else begin
      sync1 <= gpio_in;
      sync2 <= sync1;
      prev  <= sync2;
      // A fresh hit overrides a W1C of the same bit in the same cycle
      irq_stat <= (irq_stat & ~w1c) | hit;

      case (state)
        S_IDLE: begin
          if (sel) begin
            state       <= S_ACK;
            iomem_ready <= 1'b1;
            iomem_rdata <= wr ? 32'h0 : {16'h0, rd_val};
          end
        end
        default: begin
          state       <= S_IDLE;
          iomem_ready <= 1'b0;
        end
      endcase

      if (wr) begin
        case (reg_idx)
          REG_OUT:     out_reg <= (out_reg & ~wmask) | wbits;
          REG_OE:      oe_reg  <= (oe_reg  & ~wmask) | wbits;
          REG_IRQ_EN:  irq_en  <= (irq_en  & ~wmask) | wbits;
          REG_IRQ_POL: irq_pol <= (irq_pol & ~wmask) | wbits;
          REG_OUT_SET: out_reg <= out_reg | wbits;
          REG_OUT_CLR: out_reg <= out_reg & ~wbits;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gpio_ctrl.sv
// tb/tb_gpio_ctrl.sv - directed self-checking bench for gpio_ctrl
module tb_gpio_ctrl;

  localparam logic [31:0] BASE = 32'h2100_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        iomem_valid = 1'b0;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb = 4'h0;
  logic [31:0] iomem_addr = 32'h0;
  logic [31:0] iomem_wdata = 32'h0;
  logic [31:0] iomem_rdata;
  logic [15:0] gpio_in = 16'h0;
  logic [15:0] gpio_out;
  logic [15:0] gpio_oeb;
  logic        irq;

  int checks = 0;
  int errors = 0;

  gpio_ctrl #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .resetn(resetn),
    .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
    .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oeb(gpio_oeb), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where ready is seen
  task automatic bus_xfer(input logic [7:0] off, input logic [31:0] data,
                          input logic [3:0] strb, output logic [31:0] rd);
    bit seen = 0;
    iomem_valid = 1'b1;
    iomem_addr  = BASE + {24'h0, off};
    iomem_wdata = data;
    iomem_wstrb = strb;
    rd = 32'hDEAD_BEEF;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (iomem_ready) begin
        seen = 1;
        rd = iomem_rdata;
      end
    end
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    if (!seen) check("bus_timeout", 32'h0, 32'h1);
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] d;
    bus_xfer(off, data, strb, d);
  endtask

  task automatic rd(input logic [7:0] off, output logic [31:0] data);
    bus_xfer(off, 32'h0, 4'h0, data);
  endtask

  initial begin
    logic [31:0] r;
    int pulses, run, max_run;

    gpio_in = 16'h5A5A;
    repeat (3) @(negedge clk);
    check("rst_oeb", {16'h0, gpio_oeb}, 32'h0000_FFFF);
    check("rst_out", {16'h0, gpio_out}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_ready", {31'h0, iomem_ready}, 32'h0);
    check("rst_rdata", iomem_rdata, 32'h0);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    rd(8'h08, r);
    check("in_after_rst", r, 32'h0000_5A5A);

    gpio_in = 16'h0000;
    repeat (4) @(negedge clk);
    wr(8'h14, 32'h0000_FFFF, 4'hF);
    rd(8'h14, r);
    check("stat_cleared", r, 32'h0);

    wr(8'h04, 32'h0000_FF00, 4'hF);
    wr(8'h00, 32'h0000_A000, 4'hF);
    check("oeb", {16'h0, gpio_oeb}, 32'h0000_00FF);
    check("out_hi", {24'h0, gpio_out[15:8]}, 32'h0000_00A0);
    wr(8'h18, 32'h0000_0B00, 4'hF);
    check("out_set", {16'h0, gpio_out}, 32'h0000_AB00);
    wr(8'h1C, 32'h0000_A000, 4'hF);
    check("out_clr", {16'h0, gpio_out}, 32'h0000_0B00);
    rd(8'h18, r);
    check("wo_reads0", r, 32'h0);

    wr(8'h00, 32'h0, 4'hF);
    wr(8'h00, 32'hFFFF_FFFF, 4'b0010);
    check("strobe_out", {16'h0, gpio_out}, 32'h0000_FF00);
    rd(8'h00, r);
    check("strobe_rd", r, 32'h0000_FF00);
    check("rd_upper0", {16'h0, r[31:16]}, 32'h0);
    wr(8'h40, 32'h0000_FFFF, 4'hF);
    rd(8'h40, r);
    check("unmapped_rd", r, 32'h0);
    check("unmapped_wr_ignored", {16'h0, gpio_out}, 32'h0000_FF00);

    wr(8'h0C, 32'h0000_0001, 4'hF);
    wr(8'h10, 32'h0000_0009, 4'hF);
    gpio_in[0] = 1'b1;
    @(negedge clk);
    check("irq_edge1", {31'h0, irq}, 32'h0);
    @(negedge clk);
    check("irq_edge2", {31'h0, irq}, 32'h0);
    @(negedge clk);
    check("irq_edge3", {31'h0, irq}, 32'h1);
    rd(8'h08, r);
    check("in_pin0", r, 32'h0000_0001);

    gpio_in[0] = 1'b0;
    repeat (4) @(negedge clk);
    rd(8'h14, r);
    check("fall_no_set", r, 32'h0000_0001);
    wr(8'h14, 32'h0000_0001, 4'hF);
    check("irq_cleared", {31'h0, irq}, 32'h0);
    rd(8'h14, r);
    check("stat_after_w1c", r, 32'h0);

    gpio_in[3] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    wr(8'h14, 32'h0000_0008, 4'hF);
    rd(8'h14, r);
    check("set_wins", r, 32'h0000_0008);
    check("irq_masked_pin3", {31'h0, irq}, 32'h0);

    wr(8'h14, 32'h0000_FFFF, 4'hF);
    wr(8'h10, 32'h0000_0000, 4'hF);
    repeat (3) @(negedge clk);
    rd(8'h14, r);
    check("pol_no_spurious", r, 32'h0);

    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr = BASE + 32'h08;
    iomem_wstrb = 4'h0;
    pulses = 0; run = 0; max_run = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (iomem_ready) begin pulses++; run++; end else run = 0;
      if (run > max_run) max_run = run;
    end
    iomem_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (iomem_ready) pulses++;
    end
    check("held_valid_pulses", pulses, 3);
    check("pulse_width", max_run, 1);

    iomem_valid = 1'b1;
    iomem_addr = 32'h2200_0000;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (iomem_ready) pulses++;
    end
    iomem_valid = 1'b0;
    check("bad_addr_no_ack", pulses, 0);

    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr = BASE;
    iomem_wdata = 32'h0000_1234;
    iomem_wstrb = 4'hF;
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    check("midreset_ready", {31'h0, iomem_ready}, 32'h0);
    check("midreset_out", {16'h0, gpio_out}, 32'h0);
    check("midreset_oeb", {16'h0, gpio_oeb}, 32'h0000_FFFF);
    @(negedge clk);
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    resetn = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
